muldiv_completion_buffer: RTL and testbench

//  Collects mul/div results from the muldiv_top result slots (2*no_MulDiv_units per cycle) into a

---
 rtl/tomasulo_pkg.sv | 22 ++
 rtl/muldiv_completion_buffer.sv | 148 ++++++++++++++
 tb/tb_muldiv_completion_buffer.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo core types and constants.
//  ALU_Result_t           : execution-unit result payload (valid, ROB index, data, exception)
//  no_MulDiv_units        : number of mul/div units; each presents two result slots per cycle
//  MULDIV_CB_DEPTH        : entries in the mul/div completion buffer
//  MULDIV_CB_STALL_THRESH : free-entry level below which mul/div dispatch is stalled
package tomasulo_pkg;

  localparam int unsigned no_MulDiv_units = 2;
  localparam int unsigned ROB_IDX_W       = 5;
  localparam int unsigned XLEN            = 32;

  typedef struct packed {
    logic                 valid;
    logic [ROB_IDX_W-1:0] ROB_index;
    logic [XLEN-1:0]      result;
    logic                 exception;
  } ALU_Result_t;

  localparam int unsigned MULDIV_CB_DEPTH        = 16;
  localparam int unsigned MULDIV_CB_STALL_THRESH = 8;

endpackage

// File: rtl/muldiv_completion_buffer.sv
// Mul/div completion buffer: collects up to IN_SLOTS results per cycle into a circular
// FIFO and presents the oldest one to the CDB, draining one entry per granted cycle.
// Ports:
//  clk, rst         clock and synchronous active-high reset
//  flush_i          discard all buffered and incoming results
//  res_in_i         result slots from muldiv_top; slot meaningful iff .valid
//  cdb_grant_i      CDB accepts out_result_o this cycle
//  out_valid_o      out_result_o holds the oldest buffered result
//  out_result_o     head entry of the buffer
//  stall_o          throttles muldiv_top dispatch when free entries run low
//  count_o          occupied entries
//  overflow_err_o   sticky: a valid result was dropped for lack of space
module muldiv_completion_buffer
  import tomasulo_pkg::*;
#(
  parameter int unsigned IN_SLOTS     = 2 * no_MulDiv_units,
  parameter int unsigned DEPTH        = MULDIV_CB_DEPTH,
  parameter int unsigned STALL_THRESH = MULDIV_CB_STALL_THRESH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush_i,
  input  ALU_Result_t                  res_in_i [IN_SLOTS],
  input  logic                         cdb_grant_i,
  output logic                         out_valid_o,
  output ALU_Result_t                  out_result_o,
  output logic                         stall_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         overflow_err_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned OFF_W = $clog2(IN_SLOTS + 1);

  typedef logic [IN_SLOTS-1:0][OFF_W-1:0] off_vec_t;

  // Per-slot write offset: number of valid slots below it (exclusive prefix popcount).
  function automatic off_vec_t slot_offsets(input logic [IN_SLOTS-1:0] mask);
    off_vec_t          off;
    logic [OFF_W-1:0]  run;
    run = '0;
    for (int unsigned s = 0; s < IN_SLOTS; s++) begin
      off[s] = run;
      run    = run + OFF_W'(mask[s]);
    end
    return off;
  endfunction

  ALU_Result_t       mem_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              out_valid_q;
  ALU_Result_t       out_result_q, out_result_d;
  logic              stall_q;
  logic              overflow_q;

  logic [IN_SLOTS-1:0] valid_mask;
  logic [IN_SLOTS-1:0] wr_en;
  off_vec_t            off;
  logic [OFF_W-1:0]    n_valid;
  logic [OFF_W-1:0]    n_wr;
  logic [CNT_W-1:0]    cap;
  logic                deq;
  logic                drop;

  // Enqueue/dequeue decisions and next-state for pointers, count and registered head.
  always_comb begin
    deq          = out_valid_q & cdb_grant_i;
    valid_mask   = '0;
    wr_en        = '0;
    n_wr         = '0;
    drop         = 1'b0;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    out_result_d = out_result_q;

    for (int unsigned s = 0; s < IN_SLOTS; s++) begin
      valid_mask[s] = res_in_i[s].valid;
    end
    off     = slot_offsets(valid_mask);
    n_valid = off[IN_SLOTS-1] + OFF_W'(valid_mask[IN_SLOTS-1]);

    // An entry freed by this cycle's dequeue can be reused by this cycle's enqueue.
    cap = CNT_W'(DEPTH) - count_q + CNT_W'(deq);

    if (flush_i) begin
      head_d       = '0;
      tail_d       = '0;
      count_d      = '0;
      out_result_d = '0;
    end else begin
      for (int unsigned s = 0; s < IN_SLOTS; s++) begin
        if (valid_mask[s] && (CNT_W'(off[s]) < cap)) begin
          wr_en[s] = 1'b1;
          n_wr     = n_wr + OFF_W'(1);
        end
      end
      drop    = CNT_W'(n_valid) > cap;
      head_d  = head_q + PTR_W'(deq);
      tail_d  = tail_q + PTR_W'(n_wr);
      count_d = count_q + CNT_W'(n_wr) - CNT_W'(deq);

      // Next head entry: from storage, or bypassed from a slot landing on it this cycle.
      out_result_d = mem_q[head_d];
      for (int unsigned s = 0; s < IN_SLOTS; s++) begin
        if (wr_en[s] && ((tail_q + PTR_W'(off[s])) == head_d)) begin
          out_result_d = res_in_i[s];
        end
      end
    end
  end

  // Pointers, count, status flags and storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      stall_q      <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      out_valid_q  <= (count_d != '0);
      out_result_q <= out_result_d;
      stall_q      <= (CNT_W'(DEPTH) - count_d) < CNT_W'(STALL_THRESH);
      overflow_q   <= overflow_q | drop;
      for (int unsigned s = 0; s < IN_SLOTS; s++) begin
        if (wr_en[s]) begin
          mem_q[tail_q + PTR_W'(off[s])] <= res_in_i[s];
        end
      end
    end
  end

  assign out_valid_o    = out_valid_q;
  assign out_result_o   = out_result_q;
  assign stall_o        = stall_q;
  assign count_o        = count_q;
  assign overflow_err_o = overflow_q;

endmodule

// File: tb/tb_muldiv_completion_buffer.sv
// Testbench for muldiv_completion_buffer: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_muldiv_completion_buffer;
  import tomasulo_pkg::*;

  localparam int unsigned IN_SLOTS = 2 * no_MulDiv_units;
  localparam int unsigned DEPTH    = MULDIV_CB_DEPTH;
  localparam int unsigned THRESH   = MULDIV_CB_STALL_THRESH;
  localparam int unsigned CNT_W    = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  ALU_Result_t       res_in [IN_SLOTS];
  logic              grant;
  logic              out_valid;
  ALU_Result_t       out_result;
  logic              stall;
  logic [CNT_W-1:0]  count;
  logic              ovf;

  ALU_Result_t model_q[$];
  bit          model_ovf;
  int          checks = 0;
  int          errors = 0;

  muldiv_completion_buffer dut (
    .clk            (clk),
    .rst            (rst),
    .flush_i        (flush),
    .res_in_i       (res_in),
    .cdb_grant_i    (grant),
    .out_valid_o    (out_valid),
    .out_result_o   (out_result),
    .stall_o        (stall),
    .count_o        (count),
    .overflow_err_o (ovf)
  );

  always #5 clk = ~clk;

  function automatic ALU_Result_t mk(input int rob, input logic [31:0] val);
    ALU_Result_t r;
    r.valid     = 1'b1;
    r.ROB_index = 5'(rob);
    r.result    = val;
    r.exception = 1'b0;
    return r;
  endfunction

  task automatic clear_res();
    for (int s = 0; s < IN_SLOTS; s++) res_in[s] = '0;
  endtask

  // Advance one clock; the model applies the same inputs at the same edge.
  task automatic tick();
    int cap;
    int wr;
    bit deq;
    @(posedge clk);
    if (rst) begin
      model_q.delete();
      model_ovf = 1'b0;
    end else begin
      deq = (model_q.size() != 0) && grant;
      cap = int'(DEPTH) - model_q.size() + (deq ? 1 : 0);
      if (deq) void'(model_q.pop_front());
      if (flush) begin
        model_q.delete();
      end else begin
        wr = 0;
        for (int s = 0; s < IN_SLOTS; s++) begin
          if (res_in[s].valid) begin
            if (wr < cap) begin
              model_q.push_back(res_in[s]);
              wr++;
            end else begin
              model_ovf = 1'b1;
            end
          end
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; grant = 1'b0; clear_res();
    tick();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    checks++; if (count !== '0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b want 0", stall); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b want 0", ovf); end
    checks++; if (out_result !== '0) begin errors++; $display("FAIL reset_out_result got %h want 0", out_result); end
  endtask

  task automatic test_single();
    res_in[0] = mk(5, 32'h1234); grant = 1'b1;
    tick();
    clear_res();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %0b want 1", out_valid); end
    checks++; if (out_result.ROB_index !== 5'd5 || out_result.result !== 32'h1234)
      begin errors++; $display("FAIL single_result got rob %0d data %h want rob 5 data 1234", out_result.ROB_index, out_result.result); end
    checks++; if (count !== CNT_W'(1)) begin errors++; $display("FAIL single_count1 got %0d want 1", count); end
    tick();
    checks++; if (count !== '0 || out_valid !== 1'b0) begin errors++; $display("FAIL single_drained got count %0d valid %0b want 0 0", count, out_valid); end
  endtask

  task automatic test_ordering();
    int exp_rob [3] = '{2, 9, 4};
    grant = 1'b1;
    res_in[3] = mk(9, 32'h99); res_in[1] = mk(2, 32'h22);
    tick();
    clear_res();
    res_in[0] = mk(4, 32'h44);
    for (int i = 0; i < 3; i++) begin
      checks++; if (out_valid !== 1'b1 || out_result.ROB_index !== 5'(exp_rob[i]))
        begin errors++; $display("FAIL order_%0d got valid %0b rob %0d want rob %0d", i, out_valid, out_result.ROB_index, exp_rob[i]); end
      tick();
      clear_res();
    end
    checks++; if (count !== '0) begin errors++; $display("FAIL order_empty got count %0d want 0", count); end
  endtask

  task automatic test_backpressure();
    grant = 1'b0;
    for (int b = 0; b < 4; b++) begin
      for (int s = 0; s < IN_SLOTS; s++) res_in[s] = mk(b * 4 + s, 32'(100 + b * 4 + s));
      tick();
      clear_res();
      checks++; if (count !== CNT_W'(4 * (b + 1))) begin errors++; $display("FAIL bp_count_%0d got %0d want %0d", b, count, 4 * (b + 1)); end
      checks++; if (stall !== (b >= 2)) begin errors++; $display("FAIL bp_stall_%0d got %0b want %0b", b, stall, b >= 2); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL bp_ovf_%0d got %0b want 0", b, ovf); end
    end
  endtask

  task automatic test_full_concurrent();
    grant = 1'b1;
    res_in[0] = mk(16, 32'd116); res_in[2] = mk(17, 32'd117);
    tick();
    clear_res();
    checks++; if (count !== CNT_W'(16)) begin errors++; $display("FAIL full_count got %0d want 16", count); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL full_ovf got %0b want 1", ovf); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL full_stall got %0b want 1", stall); end
    for (int i = 1; i <= 16; i++) begin
      checks++; if (out_valid !== 1'b1 || out_result.ROB_index !== 5'(i) || out_result.result !== 32'(100 + i))
        begin errors++; $display("FAIL full_drain_%0d got valid %0b rob %0d data %0d want rob %0d", i, out_valid, out_result.ROB_index, out_result.result, i); end
      tick();
    end
    grant = 1'b0;
    checks++; if (count !== '0 || stall !== 1'b0 || ovf !== 1'b1)
      begin errors++; $display("FAIL full_after got count %0d stall %0b ovf %0b want 0 0 1", count, stall, ovf); end
  endtask

  task automatic test_flush();
    grant = 1'b0;
    for (int s = 0; s < IN_SLOTS; s++) res_in[s] = mk(s, 32'(s));
    tick();
    clear_res();
    res_in[0] = mk(4, 32'd4); res_in[1] = mk(5, 32'd5);
    tick();
    checks++; if (count !== CNT_W'(6)) begin errors++; $display("FAIL flush_pre_count got %0d want 6", count); end
    flush = 1'b1; grant = 1'b1; res_in[2] = mk(6, 32'd6); res_in[3] = mk(7, 32'd7);
    tick();
    flush = 1'b0; grant = 1'b0; clear_res();
    checks++; if (count !== '0 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_empty got count %0d valid %0b want 0 0", count, out_valid); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL flush_ovf_kept got %0b want 1", ovf); end
    res_in[1] = mk(21, 32'hABCD);
    tick();
    clear_res();
    checks++; if (out_valid !== 1'b1 || out_result.ROB_index !== 5'd21 || count !== CNT_W'(1))
      begin errors++; $display("FAIL flush_reuse got valid %0b rob %0d count %0d want 1 21 1", out_valid, out_result.ROB_index, count); end
  endtask

  task automatic test_mid_reset();
    for (int s = 0; s < IN_SLOTS; s++) res_in[s] = mk(s + 8, 32'(s));
    tick();
    clear_res();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0 || count !== '0 || stall !== 1'b0 || ovf !== 1'b0 || out_result !== '0)
      begin errors++; $display("FAIL midrst got valid %0b count %0d stall %0b ovf %0b res %h want all 0", out_valid, count, stall, ovf, out_result); end
  endtask

  task automatic test_wrap();
    grant = 1'b0;
    for (int b = 0; b < 4; b++) begin
      clear_res();
      for (int s = 0; s < ((b == 3) ? 2 : 4); s++) res_in[s] = mk(b * 4 + s, 32'(b * 4 + s));
      tick();
    end
    clear_res();
    grant = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    grant = 1'b0;
    checks++; if (count !== '0) begin errors++; $display("FAIL wrap_pre_count got %0d want 0", count); end
    for (int s = 0; s < IN_SLOTS; s++) res_in[s] = mk(20 + s, 32'hC0DE_0000 + 32'(s));
    tick();
    clear_res();
    checks++; if (count !== CNT_W'(4)) begin errors++; $display("FAIL wrap_count got %0d want 4", count); end
    grant = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_valid !== 1'b1 || out_result.ROB_index !== 5'(20 + i) || out_result.result !== 32'hC0DE_0000 + 32'(i))
        begin errors++; $display("FAIL wrap_drain_%0d got valid %0b rob %0d data %h want rob %0d", i, out_valid, out_result.ROB_index, out_result.result, 20 + i); end
      tick();
    end
    grant = 1'b0;
  endtask

  task automatic test_random();
    int pv = 50;
    int pg = 50;
    for (int c = 0; c < 600; c++) begin
      if (c % 50 == 0) begin
        pv = $urandom_range(10, 95);
        pg = $urandom_range(0, 100);
      end
      for (int s = 0; s < IN_SLOTS; s++) begin
        res_in[s]           = '0;
        res_in[s].ROB_index = 5'($urandom());
        res_in[s].result    = $urandom();
        res_in[s].exception = 1'($urandom());
        res_in[s].valid     = ($urandom_range(0, 99) < pv);
      end
      grant = ($urandom_range(0, 99) < pg);
      flush = ($urandom_range(0, 99) < 2);
      rst   = ($urandom_range(0, 199) < 1);
      tick();
      checks++; if (count !== CNT_W'(model_q.size()))
        begin errors++; $display("FAIL rand_count c%0d got %0d want %0d", c, count, model_q.size()); end
      checks++; if (out_valid !== (model_q.size() != 0))
        begin errors++; $display("FAIL rand_valid c%0d got %0b want %0b", c, out_valid, model_q.size() != 0); end
      checks++; if (stall !== ((int'(DEPTH) - model_q.size()) < int'(THRESH)))
        begin errors++; $display("FAIL rand_stall c%0d got %0b count %0d", c, stall, model_q.size()); end
      checks++; if (ovf !== model_ovf)
        begin errors++; $display("FAIL rand_ovf c%0d got %0b want %0b", c, ovf, model_ovf); end
      if (model_q.size() != 0) begin
        checks++; if (out_result !== model_q[0])
          begin errors++; $display("FAIL rand_head c%0d got %h want %h", c, out_result, model_q[0]); end
      end
    end
    rst = 1'b0; flush = 1'b0; grant = 1'b0; clear_res();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; grant = 1'b0; clear_res();
    test_reset();
    test_single();
    test_ordering();
    test_backpressure();
    test_full_concurrent();
    test_flush();
    test_mid_reset();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
